// File: rtl/fmsg_pkg.sv
// Shared fmsg constants: byte field positions, frame sizing and transmitter state encodings.
// Also used by fmsg_decoder and the receive deframer.
package fmsg_pkg;
    localparam int TYPE_MSB    = 7;
    localparam int TYPE_LSB    = 6;
    localparam int DEST_MSB    = 5;
    localparam int DEST_LSB    = 4;
    localparam int PAYLOAD_MSB = 3;
    localparam int PAYLOAD_LSB = 0;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic logic [DATA_BITS-1:0] pack_fmsg(input logic [1:0] msg_type,
                                                       input logic [1:0] dest,
                                                       input logic [3:0] payload);
        logic [DATA_BITS-1:0] b;
        b = '0;
        b[TYPE_MSB:TYPE_LSB]       = msg_type;
        b[DEST_MSB:DEST_LSB]       = dest;
        b[PAYLOAD_MSB:PAYLOAD_LSB] = payload;
        return b;
    endfunction
endpackage

// File: rtl/fmsg_fifo.sv
// Small synchronous FIFO with occupancy count; pop data is the combinational head entry.
module fmsg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fmsg_tx.sv
// fmsg transmitter: packs fields into a byte, queues it, and sends start/8 data MSB-first/
// even parity/stop on tx_line, each bit CLKS_PER_BIT cycles long.
module fmsg_tx
    import fmsg_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_type,
    input  logic [1:0]                      in_dest,
    input  logic [3:0]                      in_payload,
    output logic                            tx_line,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int CYC_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign bit_end  = (cyc_cnt == CYC_W'(CLKS_PER_BIT - 1));
    // The next byte is taken either from idle or on the final stop cycle, so frames abut.
    assign pop      = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

    fmsg_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pack_fmsg(in_type, in_dest, in_payload)),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_line <= 1'b1;
            tx_busy <= 1'b0;
            shift   <= '0;
            parity  <= 1'b0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift   <= head;
                        parity  <= ^head;
                        tx_line <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        tx_line <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx_line <= shift[DATA_BITS-1];
                        state   <= ST_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            tx_line <= parity;
                            state   <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift << 1;
                            tx_line <= shift[DATA_BITS-2];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx_line <= 1'b1;
                        state   <= ST_STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (pop) begin
                            shift   <= head;
                            parity  <= ^head;
                            tx_line <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            tx_line <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmsg_tx.sv
// Self-checking bench for fmsg_tx: a line deframer and field decoder act as the far end,
// and a byte-level reference model supplies every expected frame.
module tb_fmsg_tx;
    import fmsg_pkg::*;

    localparam int CPB        = 4;
    localparam int DEPTH      = 4;
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_type = '0;
    logic [1:0] in_dest = '0;
    logic [3:0] in_payload = '0;
    wire        in_ready;
    wire        tx_line;
    wire        tx_busy;
    wire  [2:0] fifo_count;

    fmsg_tx #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_dest    (in_dest),
        .in_payload (in_payload),
        .tx_line    (tx_line),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    // Far-end deframer: samples mid-bit, records byte, parity bit, stop bit and start time.
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    logic       rx_stop_q[$];
    int         rx_t0_q[$];
    logic [7:0] mon_data;
    logic       mon_par;
    logic       mon_stop;
    int         mon_t0;
    bit         mon_abort;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_line === 1'b0) begin
                mon_t0    = cyc;
                mon_abort = 0;
                mon_data  = '0;
                mon_par   = 1'b0;
                mon_stop  = 1'b0;
                for (int c = 1; c <= 42; c++) begin
                    @(negedge clk);
                    if (rst) begin
                        mon_abort = 1;
                        break;
                    end
                    if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) mon_data = {mon_data[6:0], tx_line};
                    if (c == 38) mon_par = tx_line;
                    if (c == 42) mon_stop = tx_line;
                end
                if (!mon_abort) begin
                    rx_q.push_back(mon_data);
                    rx_par_q.push_back(mon_par);
                    rx_stop_q.push_back(mon_stop);
                    rx_t0_q.push_back(mon_t0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: line levels of a frame in transmit order (start, data MSB first, parity, stop).
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[7-i];
        f[9]  = ($countones(b) % 2) == 1;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic drive_fields(input logic [7:0] b);
        in_type    = b[7:6];
        in_dest    = b[5:4];
        in_payload = b[3:0];
    endtask

    task automatic push_byte(input logic [7:0] b, output int edge_cyc, output bit ok);
        ok = 0;
        in_valid = 1'b1;
        drive_fields(b);
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        in_valid = 1'b0;
        if (ok) exp_q.push_back(b);
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 0;
        for (int w = 0; w < 3000; w++) begin
            if (rx_q.size() >= n) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 3000; w++) begin
            if (tx_busy === 1'b0 && fifo_count === 3'd0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        rx_q.delete();
        rx_par_q.delete();
        rx_stop_q.delete();
        rx_t0_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int low_seen;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (tx_line !== 1'b1) begin n_err++; $display("FAIL reset_tx_line: got %b expected 1", tx_line); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        low_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_line !== 1'b1 || tx_busy !== 1'b0) low_seen++;
        end
        n_cmp++; if (low_seen != 0 || rx_q.size() != 0) begin
            n_err++; $display("FAIL idle_quiet: got %0d active samples, %0d frames expected 0", low_seen, rx_q.size());
        end
    endtask

    task automatic test_single();
        int         n;
        bit         ok;
        logic [10:0] f;
        logic [7:0] b;
        b = pack_fmsg(2'b01, 2'b10, 4'b1111);
        f = ref_frame(b);
        push_byte(b, n, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_push: got not accepted expected accepted"); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL single_count_n: got %0d expected 1", fifo_count); end
        @(posedge clk); #1;
        n_cmp++; if (tx_line !== 1'b0) begin n_err++; $display("FAIL single_start_latency: got %b expected 0 at N+1", tx_line); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL single_count_n1: got %0d expected 0", fifo_count); end
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 11; k++) begin
            n_cmp++; if (tx_line !== f[k]) begin n_err++; $display("FAIL single_bit%0d: got %b expected %b", k, tx_line, f[k]); end
            if (k < 10) begin repeat (4) @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        n_cmp++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_n44: got %b expected 1", tx_busy); end
        @(posedge clk); #1;
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_n45: got %b expected 0", tx_busy); end
        wait_rx(1, ok);
        n_cmp++; if (!ok || rx_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL single_rx_byte: got %h expected %h", ok ? rx_q[0] : 8'hxx, exp_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] b0, b1;
        b0 = 8'hC1;
        b1 = 8'h1A;
        in_valid = 1'b1;
        drive_fields(b0);
        @(posedge clk); #1;
        exp_q.push_back(b0);
        drive_fields(b1);
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL b2b_count0: got %0d expected 1", fifo_count); end
        @(posedge clk); #1;
        exp_q.push_back(b1);
        in_valid = 1'b0;
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL b2b_count1: got %0d expected 1", fifo_count); end
        repeat (FRAME_CLKS) @(posedge clk); #1;
        n_cmp++; if (fifo_count !== 3'd0 || tx_busy !== 1'b1 || tx_line !== 1'b0) begin
            n_err++; $display("FAIL b2b_handover: got count=%0d busy=%b line=%b expected 0,1,0", fifo_count, tx_busy, tx_line);
        end
        wait_rx(2, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_frames: got %0d frames expected 2", rx_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                logic [10:0] f;
                f = ref_frame(exp_q[i]);
                n_cmp++; if (rx_q[i] !== exp_q[i] || rx_par_q[i] !== f[9] || rx_stop_q[i] !== 1'b1) begin
                    n_err++; $display("FAIL b2b_frame%0d: got %h par=%b stop=%b expected %h par=%b stop=1",
                                      i, rx_q[i], rx_par_q[i], rx_stop_q[i], exp_q[i], f[9]);
                end
            end
            n_cmp++; if (rx_t0_q[1] - rx_t0_q[0] != FRAME_CLKS) begin
                n_err++; $display("FAIL b2b_gap: got %0d cycles expected %0d", rx_t0_q[1] - rx_t0_q[0], FRAME_CLKS);
            end
        end
    endtask

    task automatic test_hold_valid();
        logic [7:0] bytes[6];
        int  idx;
        int  ready_bad;
        bit  saw_full;
        bit  saw_recover;
        bit  accept;
        bit  ok;
        for (int i = 0; i < 6; i++) begin
            bit dup;
            do begin
                bytes[i] = 8'($urandom);
                dup = 0;
                for (int j = 0; j < i; j++) if (bytes[j] == bytes[i]) dup = 1;
            end while (dup);
        end
        idx = 0; ready_bad = 0; saw_full = 0; saw_recover = 0;
        in_valid = 1'b1;
        drive_fields(bytes[0]);
        for (int w = 0; w < 2000 && idx < 6; w++) begin
            @(negedge clk);
            if (in_ready !== (fifo_count != 3'(DEPTH))) ready_bad++;
            if (fifo_count == 3'(DEPTH) && in_ready === 1'b0) saw_full = 1;
            if (saw_full && in_ready === 1'b1) saw_recover = 1;
            accept = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (accept) begin
                exp_q.push_back(bytes[idx]);
                idx++;
                if (idx < 6) drive_fields(bytes[idx]);
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (idx != 6) begin n_err++; $display("FAIL hold_accepted: got %0d expected 6", idx); end
        n_cmp++; if (ready_bad != 0) begin n_err++; $display("FAIL hold_in_ready: got %0d bad cycles expected 0", ready_bad); end
        n_cmp++; if (!saw_full || !saw_recover) begin
            n_err++; $display("FAIL hold_full: got full=%0d recover=%0d expected 1,1", saw_full, saw_recover);
        end
        wait_rx(6, ok);
        repeat (3 * FRAME_CLKS) @(posedge clk); #1;
        n_cmp++; if (rx_q.size() != 6) begin n_err++; $display("FAIL hold_frame_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== bytes[i]) begin n_err++; $display("FAIL hold_order%0d: got %h expected %h", i, rx_q[i], bytes[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int  n, n2, e;
        bit  ok;
        logic [7:0] b;
        push_byte(8'($urandom), n, ok);
        push_byte(8'($urandom), n2, ok);
        push_byte(8'($urandom), n2, ok);
        repeat (16) @(posedge clk); #1;
        n_cmp++; if (tx_busy !== 1'b1 || fifo_count !== 3'd2) begin
            n_err++; $display("FAIL rstmid_pre: got busy=%b count=%0d expected 1,2", tx_busy, fifo_count);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (tx_line !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_post: got line=%b count=%0d busy=%b ready=%b expected 1,0,0,1",
                              tx_line, fifo_count, tx_busy, in_ready);
        end
        exp_q.delete();
        repeat (10) @(posedge clk); #1;
        n_cmp++; if (rx_q.size() != 0 || tx_line !== 1'b1) begin
            n_err++; $display("FAIL rstmid_quiet: got frames=%0d line=%b expected 0,1", rx_q.size(), tx_line);
        end
        b = 8'($urandom);
        push_byte(b, e, ok);
        wait_rx(1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_newframe: got no frame expected %h", b); end
        else begin
            logic [10:0] f;
            f = ref_frame(b);
            n_cmp++; if (rx_q[0] !== b || rx_par_q[0] !== f[9] || rx_stop_q[0] !== 1'b1 || rx_t0_q[0] != e + 1) begin
                n_err++; $display("FAIL rstmid_clean: got %h par=%b stop=%b start=%0d expected %h par=%b stop=1 start=%0d",
                                  rx_q[0], rx_par_q[0], rx_stop_q[0], rx_t0_q[0], b, f[9], e + 1);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] msgs[5];
        logic [1:0] t_q[5];
        logic [1:0] d_q[5];
        logic [3:0] p_q[5];
        int  e;
        bit  ok;
        msgs[0] = 8'h6F; msgs[1] = 8'hC1; msgs[2] = 8'h1A; msgs[3] = 8'h00; msgs[4] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            t_q[i] = 2'(msgs[i] / 64);
            d_q[i] = 2'((msgs[i] / 16) % 4);
            p_q[i] = 4'(msgs[i] % 16);
            push_byte(msgs[i], e, ok);
        end
        wait_rx(5, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL loop_frames: got %0d expected 5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            logic [7:0] r;
            r = rx_q[i];
            n_cmp++; if (r[TYPE_MSB:TYPE_LSB] !== t_q[i] || r[DEST_MSB:DEST_LSB] !== d_q[i] ||
                         r[PAYLOAD_MSB:PAYLOAD_LSB] !== p_q[i]) begin
                n_err++; $display("FAIL loop_fields%0d: got t=%b d=%b p=%b expected t=%b d=%b p=%b", i,
                                  r[7:6], r[5:4], r[3:0], t_q[i], d_q[i], p_q[i]);
            end
            n_cmp++; if (($countones({r, rx_par_q[i]}) % 2) != 0 || rx_stop_q[i] !== 1'b1) begin
                n_err++; $display("FAIL loop_parity%0d: got par=%b stop=%b for %h expected even parity, stop=1",
                                  i, rx_par_q[i], rx_stop_q[i], r);
            end
        end
    endtask

    initial begin
        test_reset();
        wait_idle();
        test_single();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_hold_valid();
        wait_idle();
        test_reset_mid();
        wait_idle();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
